// File: rtl/pulse_gate_counter_if.sv
// rtl/pulse_gate_counter_if.sv - control, pulse and readout bundle for pulse_gate_counter
interface pulse_gate_counter_if #(
    parameter int P_N_CH  = 8,
    parameter int P_CNT_W = 32,
    parameter int P_SEL_W = 3
);
    logic [P_N_CH-1:0]  pulse_in;
    logic [P_N_CH-1:0]  ch_en;
    logic [P_CNT_W-1:0] limit;
    logic               run;
    logic               stop;
    logic               clr;
    logic [P_N_CH-1:0]  pulse_out;
    logic               running;
    logic [P_N_CH-1:0]  ch_done;
    logic               all_done;
    logic               rd_req;
    logic [P_SEL_W-1:0] rd_sel;
    logic [P_CNT_W-1:0] rd_data;
    logic               rd_valid;

    modport master (
        output pulse_in, ch_en, limit, run, stop, clr, rd_req, rd_sel,
        input  pulse_out, running, ch_done, all_done, rd_data, rd_valid
    );

    modport slave (
        input  pulse_in, ch_en, limit, run, stop, clr, rd_req, rd_sel,
        output pulse_out, running, ch_done, all_done, rd_data, rd_valid
    );
endinterface

// File: rtl/pulse_gate_counter.sv
// rtl/pulse_gate_counter.sv - N-channel run/stop/clear pulse gate with saturating counters and readout
module pulse_gate_counter #(
    parameter int P_N_CH      = 8,
    parameter int P_CNT_W     = 32,
    parameter int P_EDGE_MODE = 0,
    parameter int P_SEL_W     = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pulse_gate_counter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

    localparam logic [P_CNT_W-1:0] LP_ONES = '1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [P_CNT_W-1:0] r_cnt [P_N_CH];
    logic [P_CNT_W-1:0] r_lim_q;
    logic [P_N_CH-1:0]  r_pulse_d;
    logic [P_CNT_W-1:0] r_rd_data;
    logic               r_rd_valid;
    logic [P_N_CH-1:0]  w_hit;
    logic [P_N_CH-1:0]  w_q;
    logic [P_N_CH-1:0]  w_cnt_done;
    logic [P_N_CH-1:0]  w_en_done;
    logic               w_all_en_done;
    logic               w_start;
    logic [P_CNT_W-1:0] w_rd_mux;

    // w_en_done looks one cycle ahead so DONE is entered together with the final count
    always_comb begin
        w_hit      = '0;
        w_q        = '0;
        w_cnt_done = '0;
        w_en_done  = '0;
        for (int i = 0; i < P_N_CH; i++) begin
            w_hit[i]      = (P_EDGE_MODE != 0) ? (bus.pulse_in[i] & ~r_pulse_d[i]) : bus.pulse_in[i];
            w_cnt_done[i] = (r_cnt[i] == r_lim_q);
            w_q[i]        = (r_state == S_RUN) & bus.ch_en[i] & ~w_cnt_done[i] & w_hit[i];
            w_en_done[i]  = ~bus.ch_en[i] | ((r_cnt[i] + P_CNT_W'(w_q[i])) == r_lim_q);
        end
    end

    assign w_all_en_done = (&w_en_done) & (|bus.ch_en);

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clr) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.run) w_state_nxt = S_RUN;
                S_RUN: begin
                    if (bus.stop)         w_state_nxt = S_HOLD;
                    else if (w_all_en_done) w_state_nxt = S_DONE;
                end
                S_HOLD:  if (!bus.stop && bus.run) w_state_nxt = S_RUN;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign w_start = (r_state == S_IDLE) && (w_state_nxt == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_lim_q   <= LP_ONES;
            r_pulse_d <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pulse_d <= bus.pulse_in;
            if (w_start) r_lim_q <= (bus.limit == '0) ? LP_ONES : bus.limit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_N_CH; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < P_N_CH; i++) begin
                if (bus.clr)     r_cnt[i] <= '0;
                else if (w_q[i]) r_cnt[i] <= r_cnt[i] + 1'b1;
            end
        end
    end

    // Out-of-range selects match no channel and read back as zero
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < P_N_CH; i++) begin
            if (bus.rd_sel == P_SEL_W'(i)) w_rd_mux = r_cnt[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= bus.rd_req;
            if (bus.rd_req) r_rd_data <= w_rd_mux;
        end
    end

    assign bus.pulse_out = w_q;
    assign bus.running   = (r_state == S_RUN);
    assign bus.all_done  = (r_state == S_DONE);
    assign bus.ch_done   = w_cnt_done;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
endmodule
